// File: rtl/bitserial_fir_ntap_if.sv
// bitserial_fir_ntap_if: frame handshake, serial data and coefficient bundle for bitserial_fir_ntap
interface bitserial_fir_ntap_if #(
  parameter int N_TAPS = 8,
  parameter int NB_COEFF = 8
);
  logic i_en;
  logic i_start;
  logic i_data;
  logic [N_TAPS*NB_COEFF-1:0] i_coeff;
  logic o_start;
  logic o_data;
  logic o_sat;
  logic o_overrun;
  modport master(output i_en, i_start, i_data, i_coeff, input o_start, o_data, o_sat, o_overrun);
  modport slave(input i_en, i_start, i_data, i_coeff, output o_start, o_data, o_sat, o_overrun);
endinterface

// File: rtl/bitserial_fir_ntap.sv
// bitserial_fir_ntap: framed bit-serial N-tap FIR (clk, i_rst, bus slave); define BSFIR_ROUND_EN for round-half-up requantisation
module bitserial_fir_ntap #(
  parameter int NB_DATA = 8,
  parameter int NBF_DATA = 7,
  parameter int NB_COEFF = 8,
  parameter int NBF_COEFF = 7,
  parameter int N_TAPS = 8,
  parameter int NB_OUT = 8,
  parameter int NBF_OUT = 7
) (
  input logic clk,
  input logic i_rst,
  bitserial_fir_ntap_if.slave bus
);
  localparam int NB_ACC = NB_DATA + NB_COEFF + $clog2(N_TAPS);
  localparam int FRAME_LEN = NB_ACC;
  localparam int DROP = NBF_DATA + NBF_COEFF - NBF_OUT;
  localparam int CW = $clog2(FRAME_LEN);
  localparam int OW = $clog2(NB_OUT + 1);
  localparam int JW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic signed [NB_ACC:0] MAXV = (NB_ACC+1)'((1 << (NB_OUT - 1)) - 1);
  localparam logic signed [NB_ACC:0] MINV = -MAXV - 1;
`ifdef BSFIR_ROUND_EN
  localparam logic signed [NB_ACC:0] RND = (DROP > 0) ? (NB_ACC+1)'(1) << ((DROP > 0) ? DROP - 1 : 0) : '0;
`endif
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cyc;
  logic signed [NB_ACC-1:0] acc_q, acc_d, psum, term;
  logic [N_TAPS*NB_COEFF-1:0] coeff_q, coeff_d;
  logic [NB_DATA-1:0] sh_q, sh_d;
  logic [NB_DATA-1:0] hist_q [N_TAPS-1];
  logic [NB_DATA-1:0] hist_d [N_TAPS-1];
  logic [NB_OUT-1:0] osr_q, osr_d, qout;
  logic [OW-1:0] ocnt_q, ocnt_d;
  logic pend_q, pend_d, psat_q, psat_d;
  logic o_start_q, o_start_d, o_data_q, o_data_d, o_sat_q, o_sat_d, o_overrun_q, o_overrun_d;
  logic busy, last, go, act, shin, shift, qsat;
  logic signed [NB_ACC:0] ext, rnd, qv;
  always_comb begin
    busy = state_q == RUN;
    last = busy && cnt_q == CW'(FRAME_LEN - 1);
    go = bus.i_start && (!busy || last);
    act = busy || go;
    cyc = go ? '0 : cnt_q;
    shin = act && cyc < CW'(NB_DATA);
    coeff_d = go ? bus.i_coeff : coeff_q;
    hist_d = hist_q;
    if (last) begin
      hist_d[0] = sh_q;
      for (int k = 1; k < N_TAPS - 1; k++) hist_d[k] = hist_q[k-1];
    end
    psum = bus.i_data ? NB_ACC'(signed'(coeff_d[NB_COEFF-1:0])) : '0;
    for (int k = 1; k < N_TAPS; k++)
      psum = psum + (hist_d[k-1][cyc[JW-1:0]] ? NB_ACC'(signed'(coeff_d[k*NB_COEFF +: NB_COEFF])) : '0);
    term = !shin ? '0 : (cyc == CW'(NB_DATA - 1)) ? -(psum <<< cyc) : psum <<< cyc;
    acc_d = act ? (go ? '0 : acc_q) + term : acc_q;
    sh_d = shin ? {bus.i_data, sh_q[NB_DATA-1:1]} : sh_q;
    cnt_d = go ? CW'(1) : busy ? cnt_q + CW'(1) : cnt_q;
    state_d = go ? RUN : last ? IDLE : state_q;
    o_overrun_d = o_overrun_q || (bus.i_start && busy && !last);
    ext = (NB_ACC+1)'(acc_q);
`ifdef BSFIR_ROUND_EN
    rnd = ext + RND;
`else
    rnd = ext;
`endif
    qv = rnd >>> DROP;
    qsat = qv > MAXV || qv < MINV;
    qout = qv > MAXV ? {1'b0, {(NB_OUT-1){1'b1}}} : qv < MINV ? {1'b1, {(NB_OUT-1){1'b0}}} : qv[NB_OUT-1:0];
    shift = pend_q || ocnt_q != '0;
    pend_d = last;
    psat_d = last ? qsat : psat_q;
    osr_d = last ? qout : shift ? osr_q >> 1 : osr_q;
    ocnt_d = pend_q ? OW'(NB_OUT - 1) : ocnt_q != '0 ? ocnt_q - OW'(1) : ocnt_q;
    o_start_d = pend_q;
    o_data_d = shift && osr_q[0];
    o_sat_d = pend_q ? psat_q : ocnt_q != '0 && o_sat_q;
  end
  always_ff @(posedge clk)
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      coeff_q <= '0;
      sh_q <= '0;
      hist_q <= '{default: '0};
      osr_q <= '0;
      ocnt_q <= '0;
      pend_q <= 1'b0;
      psat_q <= 1'b0;
      o_start_q <= 1'b0;
      o_data_q <= 1'b0;
      o_sat_q <= 1'b0;
      o_overrun_q <= 1'b0;
    end else if (bus.i_en) begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      coeff_q <= coeff_d;
      sh_q <= sh_d;
      hist_q <= hist_d;
      osr_q <= osr_d;
      ocnt_q <= ocnt_d;
      pend_q <= pend_d;
      psat_q <= psat_d;
      o_start_q <= o_start_d;
      o_data_q <= o_data_d;
      o_sat_q <= o_sat_d;
      o_overrun_q <= o_overrun_d;
    end
  assign bus.o_start = o_start_q;
  assign bus.o_data = o_data_q;
  assign bus.o_sat = o_sat_q;
  assign bus.o_overrun = o_overrun_q;
endmodule

// File: tb/tb_bitserial_fir_ntap.sv
// tb_bitserial_fir_ntap: scoreboard bench driving random serial frames against an arithmetic FIR model
module tb_bitserial_fir_ntap;
  localparam int NB_DATA = 8, NBF_DATA = 7, NB_COEFF = 8, NBF_COEFF = 7, N_TAPS = 8, NB_OUT = 8, NBF_OUT = 7;
  localparam int FRAME_LEN = NB_DATA + NB_COEFF + $clog2(N_TAPS);
  localparam int DROP = NBF_DATA + NBF_COEFF - NBF_OUT;
  localparam longint MAXO = (longint'(1) << (NB_OUT - 1)) - 1;
  localparam longint MINO = -(longint'(1) << (NB_OUT - 1));
  typedef struct {
    int val;
    bit sat;
    int t0;
  } exp_t;
  logic clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 clk = ~clk;
  bitserial_fir_ntap_if #(.N_TAPS(N_TAPS), .NB_COEFF(NB_COEFF)) bus();
  bitserial_fir_ntap #(
    .NB_DATA(NB_DATA), .NBF_DATA(NBF_DATA), .NB_COEFF(NB_COEFF), .NBF_COEFF(NBF_COEFF),
    .N_TAPS(N_TAPS), .NB_OUT(NB_OUT), .NBF_OUT(NBF_OUT)
  ) dut (
    .clk(clk),
    .i_rst(i_rst),
    .bus(bus)
  );
  exp_t q[$];
  int hist[$];
  int tests = 0, fails = 0, ecnt = 0;
  int idx = 0, got = 0;
  bit coll = 1'b0, en_s, rs_s;
  exp_t cur;
  logic [N_TAPS*NB_COEFF-1:0] c;
  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    en_s = bus.i_en;
    rs_s = i_rst;
    #1;
    if (rs_s) coll = 1'b0;
    else if (en_s) begin
      ecnt++;
      if (bus.o_start) begin
        if (q.size() == 0) check("unexpected_o_start", 1, 0);
        else begin
          cur = q.pop_front();
          check("o_start_time", ecnt, cur.t0 + FRAME_LEN);
          coll = 1'b1;
          idx = 0;
          got = 0;
        end
      end
      if (coll) begin
        got |= int'(bus.o_data) << idx;
        check("o_sat_window", int'(bus.o_sat), int'(cur.sat));
        idx++;
        if (idx == NB_OUT) begin
          coll = 1'b0;
          check("o_data_word", got, cur.val);
        end
      end else if (!bus.o_start) begin
        check("idle_o_data", int'(bus.o_data), 0);
        check("idle_o_sat", int'(bus.o_sat), 0);
      end
    end
  end
  task automatic clear_hist();
    hist = {};
    repeat (N_TAPS) hist.push_back(0);
  endtask
  task automatic drive(bit st, bit d);
    @(negedge clk);
    bus.i_en = 1'b1;
    bus.i_start = st;
    bus.i_data = d;
  endtask
  task automatic stall(int n);
    repeat (n) begin
      @(negedge clk);
      bus.i_en = 1'b0;
      bus.i_start = 1'($urandom);
      bus.i_data = 1'($urandom);
    end
  endtask
  task automatic idle(int n);
    repeat (n) drive(1'b0, 1'($urandom));
  endtask
  task automatic frame(logic [NB_DATA-1:0] x, logic [N_TAPS*NB_COEFF-1:0] cf, int ovr_at, int stall_at);
    int t0;
    longint y;
    exp_t e;
    t0 = 0;
    for (int j = 0; j < FRAME_LEN - 1; j++) begin
      if (j == stall_at) stall(3);
      drive(j == 0 || j == ovr_at, j < NB_DATA ? x[j] : 1'($urandom));
      if (j == 0) begin
        bus.i_coeff = cf;
        t0 = ecnt + 1;
      end
    end
    hist.push_front(int'($signed(x)));
    void'(hist.pop_back());
    y = 0;
    for (int k = 0; k < N_TAPS; k++) y += longint'($signed(cf[k*NB_COEFF +: NB_COEFF])) * hist[k];
`ifdef BSFIR_ROUND_EN
    if (DROP > 0) y += longint'(1) << (DROP - 1);
`endif
    y = y >>> DROP;
    e.sat = y > MAXO || y < MINO;
    y = y > MAXO ? MAXO : y < MINO ? MINO : y;
    e.val = int'(y) & ((1 << NB_OUT) - 1);
    e.t0 = t0;
    q.push_back(e);
  endtask
  task automatic impulse_run();
    for (int k = 0; k < N_TAPS; k++) c[k*NB_COEFF +: NB_COEFF] = NB_COEFF'(16 * (k + 1));
    frame(8'h40, c, -1, -1);
    repeat (9) frame(8'h00, c, -1, -1);
    idle(2 * FRAME_LEN);
  endtask
  task automatic check_outputs_zero(string tag);
    check({tag, "_o_start"}, int'(bus.o_start), 0);
    check({tag, "_o_data"}, int'(bus.o_data), 0);
    check({tag, "_o_sat"}, int'(bus.o_sat), 0);
    check({tag, "_o_overrun"}, int'(bus.o_overrun), 0);
  endtask
  initial begin
    bus.i_en = 1'b0;
    bus.i_start = 1'b0;
    bus.i_data = 1'b0;
    bus.i_coeff = '0;
    clear_hist();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    i_rst = 1'b0;
    impulse_run();
    c = {N_TAPS{8'h7F}};
    repeat (8) frame(8'h7F, c, -1, -1);
    repeat (8) frame(8'h80, c, -1, -1);
    idle(2);
    c = '0;
    c[7:0] = 8'h01;
    frame(8'h40, c, -1, -1);
    idle(1);
    c = {N_TAPS{8'h21}};
    frame(8'h5A, c, -1, 7);
    frame(8'hC3, c, -1, 12);
    idle(3);
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < N_TAPS; k++) c[k*NB_COEFF +: NB_COEFF] = NB_COEFF'($urandom_range(0, 255) >> $urandom_range(0, 3));
      frame(NB_DATA'($urandom), c, -1, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, FRAME_LEN - 2)) : -1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end
    idle(2 * FRAME_LEN);
    check("overrun_before", int'(bus.o_overrun), 0);
    frame(NB_DATA'($urandom), c, 5, -1);
    idle(1);
    check("overrun_after", int'(bus.o_overrun), 1);
    idle(2 * FRAME_LEN);
    for (int j = 0; j < 10; j++) drive(j == 0, j < NB_DATA ? 1'(8'h40 >> j) : 1'b0);
    @(negedge clk);
    i_rst = 1'b1;
    @(posedge clk);
    #2;
    check_outputs_zero("midreset");
    @(negedge clk);
    i_rst = 1'b0;
    clear_hist();
    idle(2 * FRAME_LEN);
    impulse_run();
    check("queue_empty", q.size(), 0);
    check("no_partial_word", int'(coll), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
